cmd_frame_decoder: RTL
======================

# cmd_frame_decoder

Parametrised multi-channel command-frame decoder for the UART sampling controller. It sits between the UART 48-bit frame assembler and the per-channel ADC sampling engines. Each received frame is checked for header, address and checksum, then decoded into per-channel sampling-rate and sampling-point configuration writes. A checksummed 48-bit response frame goes back to the UART transmitter through a valid/ready handshake.

## Interface
Parameters:
- `NUM_CH`, 4: number of ADC channels, 1..16.
- `LOCAL_ADDR`, 8'h03: this board's address.
- `BCAST_ADDR`, 8'hFF: broadcast address.
- `HEAD`, 8'hF0: required header byte.
- `RATE_MAX`, 6: largest legal rate code. Legal range is 1..RATE_MAX.
- `RATE_RST`, 5: reset rate code (20 MSPS).
- `POINT_RST`, 1: reset sampling-point count.

Ports (reset is rst_n, asynchronous, active-low; clock is clk):
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `frame_valid` in 1: a frame is present on `frame_data`.
- `frame_ready` out 1: block accepts a frame; high only in IDLE.
- `frame_data` in 48: frame bytes [47:40] head, [39:32] addr, [31:24] func, [23:8] payload, [7:0] checksum.
- `rsp_valid` out 1: response frame valid.
- `rsp_ready` in 1: transmitter accepts the response.
- `rsp_data` out 48: response frame, same layout.
- `cfg_rate` out NUM_CH*16: per-channel rate code; channel c occupies [16c+15:16c].
- `cfg_point` out NUM_CH*16: per-channel sampling-point count, same packing.
- `cfg_upd` out NUM_CH: one-cycle pulse per channel whose configuration changed.
- `data_return_req` out 1: one-cycle pulse requesting a sample dump.
- `req_ch` out 4: channel index for `data_return_req`.
- `err_cnt` out 8: saturating count of header/checksum errors.

## Operation
- func byte layout: func[7:4] is the channel, func[2:0] is the opcode.
  - 1: set rate.
  - 2: set points.
  - 3: data return.
  - 4: address inquiry.
  - 5: query points.
- Frame validity: the frame is valid when head == HEAD and checksum == XOR of bytes 5..1.
- Targeting: the frame is targeted when addr == LOCAL_ADDR, or addr == BCAST_ADDR, or opcode == 4 (any addr).
- Invalid frame:
  - `err_cnt` increments, saturating at 255.
  - If addr == LOCAL_ADDR, a NAK with status 0x0005 is returned. Otherwise the frame is dropped silently.
- Untargeted valid frame: dropped with no side effect.
- Execution (status codes: 0x0000 ACK, 0x0001 rate out of range, 0x0002 zero points, 0x0003 channel ≥ NUM_CH, 0x0004 bad opcode):
  - Opcode 1, payload in 1..RATE_MAX: write the rate and pulse `cfg_upd`. Otherwise leave it unchanged and return status 0x0001.
  - Opcode 2, payload ≠ 0: write the point count. Otherwise return status 0x0002.
  - Opcode 3: pulse `data_return_req` and drive `req_ch`.
  - Opcode 4: response payload is {8'h00, LOCAL_ADDR}.
  - Opcode 5: response payload is `cfg_point` of the channel.
- Broadcast frames ignore the channel field, apply opcodes 1 and 2 to all channels (`cfg_upd` all ones on success), and never produce a response.
- Response frame: {HEAD, LOCAL_ADDR, echoed func, payload, XOR of the preceding 5 bytes}.
- FSM states:
  - IDLE → CHECK on accept, i.e. `frame_valid && frame_ready`; the frame is latched.
  - CHECK → IDLE if the frame is dropped.
  - CHECK → EXEC otherwise.
  - EXEC → RESP if a response is due, else → IDLE.
  - RESP → IDLE on `rsp_valid && rsp_ready`.

## Timing
- Reset values:
  - FSM in IDLE.
  - `frame_ready` = 1, `rsp_valid` = 0, `rsp_data` = 0.
  - Every `cfg_rate` = RATE_RST, every `cfg_point` = POINT_RST.
  - `cfg_upd` = 0, `data_return_req` = 0, `req_ch` = 0, `err_cnt` = 0.
- Latency from the accept edge at cycle 0:
  - CHECK in cycle 1.
  - In cycle 2 (EXEC): config registers update and `cfg_upd` / `data_return_req` pulse.
  - `rsp_valid` rises in cycle 3.
  - Minimum frame-to-frame spacing is 4 cycles without backpressure.
- Handshake:
  - `rsp_valid` and `rsp_data` stay stable until `rsp_ready`.
  - `frame_ready` is 0 outside IDLE, so no frame is accepted while a response is pending.
  - `frame_valid` asserted outside IDLE is ignored (no loss is flagged; the source must hold it).
- `err_cnt` updates in the CHECK cycle.
- `cfg_upd` and `data_return_req` are high for exactly one cycle.
- Asserting `rst_n` mid-frame or mid-response aborts immediately. Outputs return to reset values and the pending response is discarded.

## Structure
- Package `cmd_frame_pkg` holds:
  - opcode constants (OP_RATE=1, OP_POINT=2, OP_RETURN=3, OP_ADDR=4, OP_QUERY=5);
  - status codes (ST_ACK … ST_CSUM);
  - the FSM state enum;
  - a byte-field extraction function.
- Sub-module `frame_xor_chk` is a 5-byte XOR checksum, instantiated twice: once for the receive check and once for the response build.

## Test plan
- Rate write: frame F0 03 11 00 04 E6 → at cycle 2 `cfg_rate` channel 1 = 4 and `cfg_upd` = 4'b0010; response F0 03 11 00 00 E2.
- Out-of-range rate: frame F0 03 01 00 07 F5 → channel 0 rate stays 5, no `cfg_upd`; response F0 03 01 00 01 F3.
- Address inquiry to a foreign address: frame F0 22 04 00 00 D6 → response F0 03 04 00 03 F4.
- Bad checksum: frame F0 03 01 00 04 00 → `err_cnt` = 1, no config change; response F0 03 01 00 05 F7.
- Broadcast points: frame F0 FF 02 00 64 69 → all `cfg_point` = 100, `cfg_upd` = 4'b1111, no `rsp_valid`.
- Backpressure and reset:
  - Hold `rsp_ready` = 0 for 10 cycles and present a second frame → `rsp_data` stable, `frame_ready` = 0, second frame not accepted.
  - Assert `rst_n` low in RESP → `rsp_valid` = 0 and all cfg at reset values.

Source files
------------

// File: rtl/cmd_frame_pkg.sv
// rtl/cmd_frame_pkg.sv - shared opcodes, status codes, FSM states and field helper for cmd_frame_decoder
package cmd_frame_pkg;

    localparam logic [2:0] OP_RATE   = 3'd1;
    localparam logic [2:0] OP_POINT  = 3'd2;
    localparam logic [2:0] OP_RETURN = 3'd3;
    localparam logic [2:0] OP_ADDR   = 3'd4;
    localparam logic [2:0] OP_QUERY  = 3'd5;

    localparam logic [15:0] ST_ACK    = 16'h0000;
    localparam logic [15:0] ST_RATE   = 16'h0001;
    localparam logic [15:0] ST_ZERO   = 16'h0002;
    localparam logic [15:0] ST_CHAN   = 16'h0003;
    localparam logic [15:0] ST_OPCODE = 16'h0004;
    localparam logic [15:0] ST_CSUM   = 16'h0005;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CHECK = 2'd1;
    localparam logic [1:0] S_EXEC  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    // Byte 5 is the header, byte 0 the checksum.
    function automatic logic [7:0] get_byte(input logic [47:0] frame, input int unsigned idx);
        return frame[8*idx +: 8];
    endfunction

endpackage

// File: rtl/frame_xor_chk.sv
// rtl/frame_xor_chk.sv - XOR checksum over the five leading bytes of a frame
module frame_xor_chk (
    input  logic [39:0] data_i,
    output logic [7:0]  csum_o
);

    assign csum_o = data_i[39:32] ^ data_i[31:24] ^ data_i[23:16] ^ data_i[15:8] ^ data_i[7:0];

endmodule

// File: rtl/cmd_frame_decoder.sv
// rtl/cmd_frame_decoder.sv - validates UART command frames, updates per-channel sampling config, builds responses
module cmd_frame_decoder
    import cmd_frame_pkg::*;
#(
    parameter int unsigned NUM_CH     = 4,
    parameter logic [7:0]  LOCAL_ADDR = 8'h03,
    parameter logic [7:0]  BCAST_ADDR = 8'hFF,
    parameter logic [7:0]  HEAD       = 8'hF0,
    parameter logic [15:0] RATE_MAX   = 16'd6,
    parameter logic [15:0] RATE_RST   = 16'd5,
    parameter logic [15:0] POINT_RST  = 16'd1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 frame_valid,
    output logic                 frame_ready,
    input  logic [47:0]          frame_data,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [47:0]          rsp_data,
    output logic [NUM_CH*16-1:0] cfg_rate,
    output logic [NUM_CH*16-1:0] cfg_point,
    output logic [NUM_CH-1:0]    cfg_upd,
    output logic                 data_return_req,
    output logic [3:0]           req_ch,
    output logic [7:0]           err_cnt
);

    logic [1:0]        state_q, state_d;
    logic [47:0]       frame_q, frame_d;
    logic [15:0]       rate_q [NUM_CH];
    logic [15:0]       rate_d [NUM_CH];
    logic [15:0]       point_q [NUM_CH];
    logic [15:0]       point_d [NUM_CH];
    logic [NUM_CH-1:0] upd_q, upd_d;
    logic              ret_q, ret_d;
    logic [3:0]        req_ch_q, req_ch_d;
    logic [7:0]        err_q, err_d;
    logic              rsp_due_q, rsp_due_d;
    logic [15:0]       rsp_pl_q, rsp_pl_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [47:0]       rsp_data_q, rsp_data_d;

    logic [7:0]  f_head, f_addr, f_func, f_csum, rx_csum, tx_csum;
    logic [15:0] f_payload;
    logic [3:0]  f_ch;
    logic [2:0]  f_op;
    logic        frame_ok, is_local, is_bcast, targeted, ch_ok, rate_ok;

    assign f_head    = get_byte(frame_q, 5);
    assign f_addr    = get_byte(frame_q, 4);
    assign f_func    = get_byte(frame_q, 3);
    assign f_csum    = get_byte(frame_q, 0);
    assign f_payload = frame_q[23:8];
    assign f_ch      = f_func[7:4];
    assign f_op      = f_func[2:0];

    frame_xor_chk u_rx_chk (
        .data_i (frame_q[47:8]),
        .csum_o (rx_csum)
    );

    frame_xor_chk u_tx_chk (
        .data_i ({HEAD, LOCAL_ADDR, f_func, rsp_pl_q}),
        .csum_o (tx_csum)
    );

    assign frame_ok = (f_head == HEAD) && (f_csum == rx_csum);
    assign is_local = (f_addr == LOCAL_ADDR);
    assign is_bcast = (f_addr == BCAST_ADDR);
    assign targeted = is_local || is_bcast || (f_op == OP_ADDR);
    assign ch_ok    = ({28'd0, f_ch} < NUM_CH);
    assign rate_ok  = (f_payload != 16'd0) && (f_payload <= RATE_MAX);

    always_comb begin
        state_d     = state_q;
        frame_d     = frame_q;
        rate_d      = rate_q;
        point_d     = point_q;
        upd_d       = '0;
        ret_d       = 1'b0;
        req_ch_d    = req_ch_q;
        err_d       = err_q;
        rsp_due_d   = rsp_due_q;
        rsp_pl_d    = rsp_pl_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;

        case (state_q)
            S_IDLE: begin
                if (frame_valid) begin
                    frame_d = frame_data;
                    state_d = S_CHECK;
                end
            end
            // All decisions are taken here so config and pulses are visible during EXEC.
            S_CHECK: begin
                rsp_due_d = 1'b0;
                rsp_pl_d  = ST_ACK;
                state_d   = S_EXEC;
                if (!frame_ok) begin
                    if (err_q != 8'hFF) err_d = err_q + 8'd1;
                    if (is_local) begin
                        rsp_due_d = 1'b1;
                        rsp_pl_d  = ST_CSUM;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (!targeted) begin
                    state_d = S_IDLE;
                end else if (is_bcast) begin
                    case (f_op)
                        OP_RATE: if (rate_ok) begin
                            for (int c = 0; c < NUM_CH; c++) rate_d[c] = f_payload;
                            upd_d = '1;
                        end
                        OP_POINT: if (f_payload != 16'd0) begin
                            for (int c = 0; c < NUM_CH; c++) point_d[c] = f_payload;
                            upd_d = '1;
                        end
                        OP_RETURN: begin
                            ret_d    = 1'b1;
                            req_ch_d = 4'd0;
                        end
                        default: ;
                    endcase
                end else begin
                    rsp_due_d = 1'b1;
                    if (f_op == OP_ADDR) begin
                        rsp_pl_d = {8'h00, LOCAL_ADDR};
                    end else if (f_op < OP_RATE || f_op > OP_QUERY) begin
                        rsp_pl_d = ST_OPCODE;
                    end else if (!ch_ok) begin
                        rsp_pl_d = ST_CHAN;
                    end else begin
                        case (f_op)
                            OP_RATE: if (!rate_ok) rsp_pl_d = ST_RATE;
                            OP_POINT: if (f_payload == 16'd0) rsp_pl_d = ST_ZERO;
                            OP_RETURN: begin
                                ret_d    = 1'b1;
                                req_ch_d = f_ch;
                            end
                            default: ;
                        endcase
                        for (int c = 0; c < NUM_CH; c++) begin
                            if (f_ch == 4'(c)) begin
                                if (f_op == OP_RATE && rate_ok) begin
                                    rate_d[c] = f_payload;
                                    upd_d[c]  = 1'b1;
                                end
                                if (f_op == OP_POINT && f_payload != 16'd0) begin
                                    point_d[c] = f_payload;
                                    upd_d[c]   = 1'b1;
                                end
                                if (f_op == OP_QUERY) rsp_pl_d = point_q[c];
                            end
                        end
                    end
                end
            end
            S_EXEC: begin
                if (rsp_due_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = {HEAD, LOCAL_ADDR, f_func, rsp_pl_q, tx_csum};
                    state_d     = S_RESP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            frame_q     <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                rate_q[c]  <= RATE_RST;
                point_q[c] <= POINT_RST;
            end
            upd_q       <= '0;
            ret_q       <= 1'b0;
            req_ch_q    <= 4'd0;
            err_q       <= 8'd0;
            rsp_due_q   <= 1'b0;
            rsp_pl_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            frame_q     <= frame_d;
            rate_q      <= rate_d;
            point_q     <= point_d;
            upd_q       <= upd_d;
            ret_q       <= ret_d;
            req_ch_q    <= req_ch_d;
            err_q       <= err_d;
            rsp_due_q   <= rsp_due_d;
            rsp_pl_q    <= rsp_pl_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
        assign cfg_rate[16*g +: 16]  = rate_q[g];
        assign cfg_point[16*g +: 16] = point_q[g];
    end

    assign frame_ready     = (state_q == S_IDLE);
    assign rsp_valid       = rsp_valid_q;
    assign rsp_data        = rsp_data_q;
    assign cfg_upd         = upd_q;
    assign data_return_req = ret_q;
    assign req_ch          = req_ch_q;
    assign err_cnt         = err_q;

endmodule
